// File: rtl/paillier_axi_lite_regs_if.sv
// ---------------------------------------------------------------------------
// paillier_axi_lite_regs_if
// AXI4-Lite bus bundle between the host/stimulus master and the Paillier
// control/status register block.
//
// Parameters
//   ADDR_W  byte address width (AW/AR channels)
//   DATA_W  data width (W/R channels); strobe width is DATA_W/8
//
// Signals (master view)
//   aw*     write address channel: awaddr, awprot, awvalid -> / <- awready
//   w*      write data channel:    wdata, wstrb, wvalid     -> / <- wready
//   b*      write response:        <- bresp, bvalid / bready ->
//   ar*     read address channel:  araddr, arprot, arvalid  -> / <- arready
//   r*      read data channel:     <- rdata, rresp, rvalid  / rready ->
//
// Modports: master (drives requests), slave (drives responses).
// ---------------------------------------------------------------------------
interface paillier_axi_lite_regs_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/paillier_axi_lite_regs.sv
// ---------------------------------------------------------------------------
// paillier_axi_lite_regs
// AXI4-Lite control/status register file for the Paillier accelerator.
// Holds the DMA source/destination addresses, issues a one-cycle start
// pulse to the core and keeps a sticky, interrupt-capable DONE flag.
//
// Register map (addr[3:2], addr[1:0] ignored, unused bits read 0)
//   0x0 CTRL     bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN (RW)
//   0x4 STATUS   bit0 BUSY (RO, live core_busy_i), bit1 DONE (W1C, sticky)
//   0x8 SRC_ADDR RW, byte strobes honoured
//   0xC DST_ADDR RW, byte strobes honoured
//
// Ports
//   S_AXI_ACLK     clock
//   S_AXI_ARESETN  asynchronous active-low reset
//   s_axi          AXI4-Lite slave bundle
//   core_busy_i    core running
//   core_done_i    one-cycle done pulse from core
//   start_o        one-cycle start pulse to core
//   src_addr_o     SRC_ADDR register
//   dst_addr_o     DST_ADDR register
//   irq_o          level interrupt, DONE & IRQ_EN
//
// Write FSM                         Read FSM
//   state  | meaning                  state  | meaning
//   W_IDLE | waiting for AW and W     R_IDLE | waiting for AR
//   W_ACK  | AWREADY/WREADY high,     R_ADDR | ARREADY high, RDATA
//          | registers updated        |        latched at end of cycle
//   W_RESP | BVALID held until BREADY R_DATA | RVALID held until RREADY
// ---------------------------------------------------------------------------
module paillier_axi_lite_regs #(
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_SRC_ADDR_RESET   = 32'h1000_0000,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_DST_ADDR_RESET   = 32'h1000_1000
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  paillier_axi_lite_regs_if.slave       s_axi,
  input  logic                          core_busy_i,
  input  logic                          core_done_i,
  output logic                          start_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] src_addr_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] dst_addr_o,
  output logic                          irq_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_SRC    = 2'd2;
  localparam logic [1:0] REG_DST    = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic          awready, wready, bvalid;
  logic          arready, rvalid;
  logic [1:0]    bresp_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rd_mux;

  logic          irq_en_q;
  logic          done_q;
  logic          start_q;
  logic [DW-1:0] src_q;
  logic [DW-1:0] dst_q;

  logic          wr_fire;
  logic [1:0]    wr_sel;
  logic [1:0]    rd_sel;
  logic          done_clr;

  // --------------------------------------------------------------------------
  // Write channel FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_next;
    end
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      // Both channels must be present together; a lone AW or W just waits.
      W_IDLE: begin
        if (s_axi.awvalid && s_axi.wvalid) w_next = W_ACK;
      end
      W_ACK: begin
        awready = 1'b1;
        wready  = 1'b1;
        w_next  = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (s_axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read channel FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_next;
    end
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (s_axi.arvalid) r_next = R_ADDR;
      end
      R_ADDR: begin
        arready = 1'b1;
        r_next  = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (s_axi.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Register updates
  // --------------------------------------------------------------------------
  // The master holds AW/W valid until the ready cycle, so W_ACK alone marks
  // the handshake edge.
  assign wr_fire  = (w_state == W_ACK);
  assign wr_sel   = s_axi.awaddr[3:2];
  assign done_clr = wr_fire && (wr_sel == REG_STATUS) && s_axi.wstrb[0] && s_axi.wdata[1];

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      irq_en_q <= 1'b0;
      start_q  <= 1'b0;
      src_q    <= C_SRC_ADDR_RESET;
      dst_q    <= C_DST_ADDR_RESET;
      bresp_q  <= RESP_OKAY;
    end else begin
      start_q <= 1'b0;
      if (wr_fire) begin
        bresp_q <= RESP_OKAY;
        case (wr_sel)
          REG_CTRL: begin
            if (s_axi.wstrb[0]) begin
              irq_en_q <= s_axi.wdata[1];
              // START while busy is refused and reported, IRQ_EN still lands.
              if (s_axi.wdata[0]) begin
                if (core_busy_i) bresp_q <= RESP_SLVERR;
                else             start_q <= 1'b1;
              end
            end
          end
          REG_SRC: begin
            for (int b = 0; b < NB; b++) begin
              if (s_axi.wstrb[b]) src_q[8*b +: 8] <= s_axi.wdata[8*b +: 8];
            end
          end
          REG_DST: begin
            for (int b = 0; b < NB; b++) begin
              if (s_axi.wstrb[b]) dst_q[8*b +: 8] <= s_axi.wdata[8*b +: 8];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A done pulse coinciding with a W1C clear leaves DONE set.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      done_q <= 1'b0;
    end else if (core_done_i) begin
      done_q <= 1'b1;
    end else if (done_clr) begin
      done_q <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Read data path
  // --------------------------------------------------------------------------
  assign rd_sel = s_axi.araddr[3:2];

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      REG_CTRL:   rd_mux = {{(DW-2){1'b0}}, irq_en_q, 1'b0};
      REG_STATUS: rd_mux = {{(DW-2){1'b0}}, done_q, core_busy_i};
      REG_SRC:    rd_mux = src_q;
      REG_DST:    rd_mux = dst_q;
      default:    rd_mux = '0;
    endcase
  end

  // Captured from pre-update register values, so a STATUS read on the same
  // edge as a DONE clear still returns DONE = 1.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rdata_q <= '0;
    end else if (r_state == R_ADDR) begin
      rdata_q <= rd_mux;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RESP_OKAY;

  assign start_o    = start_q;
  assign src_addr_o = src_q;
  assign dst_addr_o = dst_q;
  assign irq_o      = done_q & irq_en_q;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule

// File: tb/tb_paillier_axi_lite_regs.sv
module tb_paillier_axi_lite_regs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_busy_i = 1'b0;
  logic core_done_i = 1'b0;
  logic start_o;
  logic [31:0] src_addr_o;
  logic [31:0] dst_addr_o;
  logic irq_o;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  paillier_axi_lite_regs_if #(.ADDR_W(4), .DATA_W(32)) s_axi ();

  paillier_axi_lite_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (s_axi.slave),
    .core_busy_i   (core_busy_i),
    .core_done_i   (core_done_i),
    .start_o       (start_o),
    .src_addr_o    (src_addr_o),
    .dst_addr_o    (dst_addr_o),
    .irq_o         (irq_o)
  );

  always @(negedge clk) if (start_o === 1'b1) start_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input bit pulse_done, output logic [1:0] resp, output logic start_seen);
    @(negedge clk);
    s_axi.awaddr = addr; s_axi.wdata = data; s_axi.wstrb = strb;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.bready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axi.awready) break;
    end
    check("wr_awready", 32'(s_axi.awready), 32'd1);
    if (pulse_done) core_done_i = 1'b1;
    @(posedge clk); #1;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; core_done_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axi.bvalid) break;
    end
    check("wr_bvalid", 32'(s_axi.bvalid), 32'd1);
    resp = s_axi.bresp;
    start_seen = start_o;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [3:0] addr, input bit take,
                          output logic [31:0] data, output logic [1:0] resp);
    @(negedge clk);
    s_axi.araddr = addr; s_axi.arvalid = 1'b1; s_axi.rready = take;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axi.arready) break;
    end
    check("rd_arready", 32'(s_axi.arready), 32'd1);
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axi.rvalid) break;
    end
    check("rd_rvalid", 32'(s_axi.rvalid), 32'd1);
    data = s_axi.rdata;
    resp = s_axi.rresp;
    if (take) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] rd;
  logic [1:0]  resp;
  logic        st;
  logic        aw_seen;
  int          sc0;
  logic [3:0]  raddr [4] = '{4'h0, 4'h4, 4'h8, 4'hC};
  logic [31:0] rexp  [4] = '{32'h0, 32'h0, 32'h1000_0000, 32'h1000_1000};

  initial begin
    s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
    s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;

    #12;
    check("rst_awready", 32'(s_axi.awready), 32'd0);
    check("rst_bvalid",  32'(s_axi.bvalid),  32'd0);
    check("rst_rvalid",  32'(s_axi.rvalid),  32'd0);
    check("rst_rdata",   s_axi.rdata,        32'd0);
    check("rst_start",   32'(start_o),       32'd0);
    check("rst_src_o",   src_addr_o,         32'h1000_0000);
    check("rst_dst_o",   dst_addr_o,         32'h1000_1000);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      axi_read(raddr[i], 1'b1, rd, resp);
      check("rst_read", rd, rexp[i]);
      check("rst_rresp", 32'(resp), 32'd0);
    end

    // Partial-strobe SRC write: bytes 0 and 2 replaced.
    axi_write(4'h8, 32'hDEAD_BEEF, 4'b0101, 1'b0, resp, st);
    check("src_bresp", 32'(resp), 32'd0);
    check("src_o", src_addr_o, 32'h10AD_00EF);
    axi_read(4'h8, 1'b1, rd, resp);
    check("src_read", rd, 32'h10AD_00EF);
    axi_write(4'hF, 32'hCAFE_0000, 4'hF, 1'b0, resp, st);  // addr[1:0] ignored
    check("dst_o", dst_addr_o, 32'hCAFE_0000);
    axi_read(4'hC, 1'b1, rd, resp);
    check("dst_read", rd, 32'hCAFE_0000);

    // START while idle.
    sc0 = start_cnt;
    axi_write(4'h0, 32'h3, 4'h1, 1'b0, resp, st);
    check("start_bresp", 32'(resp), 32'd0);
    check("start_at_k2", 32'(st), 32'd1);
    repeat (3) @(negedge clk);
    check("start_width", 32'(start_cnt - sc0), 32'd1);
    axi_read(4'h0, 1'b1, rd, resp);
    check("ctrl_read", rd, 32'h2);

    // START while busy: refused, SLVERR, IRQ_EN cleared by bit1 = 0.
    core_busy_i = 1'b1;
    sc0 = start_cnt;
    axi_write(4'h0, 32'h1, 4'h1, 1'b0, resp, st);
    check("busy_bresp", 32'(resp), 32'd2);
    repeat (3) @(negedge clk);
    check("busy_nostart", 32'(start_cnt - sc0), 32'd0);
    axi_read(4'h4, 1'b1, rd, resp);
    check("status_busy", rd, 32'h1);
    axi_read(4'h0, 1'b1, rd, resp);
    check("ctrl_irqen_off", rd, 32'h0);
    core_busy_i = 1'b0;

    // DONE / IRQ.
    axi_write(4'h0, 32'h2, 4'h1, 1'b0, resp, st);
    check("irq_before", 32'(irq_o), 32'd0);
    @(negedge clk); core_done_i = 1'b1;
    @(negedge clk); core_done_i = 1'b0;
    check("irq_set", 32'(irq_o), 32'd1);
    axi_read(4'h4, 1'b1, rd, resp);
    check("status_done", rd, 32'h2);
    axi_write(4'h4, 32'h2, 4'b1110, 1'b0, resp, st);   // no strobe on byte 0
    check("irq_strb0", 32'(irq_o), 32'd1);
    axi_write(4'h4, 32'h2, 4'h1, 1'b1, resp, st);      // clear collides with set
    check("irq_set_wins", 32'(irq_o), 32'd1);
    axi_read(4'h4, 1'b1, rd, resp);
    check("status_set_wins", rd, 32'h2);
    axi_write(4'h4, 32'h2, 4'h1, 1'b0, resp, st);
    check("irq_cleared", 32'(irq_o), 32'd0);
    axi_read(4'h4, 1'b1, rd, resp);
    check("status_cleared", rd, 32'h0);

    // B back-pressure blocks a second write.
    @(negedge clk);
    s_axi.awaddr = 4'h8; s_axi.wdata = 32'h1111_1111; s_axi.wstrb = 4'hF;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.bready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axi.awready) break;
    end
    check("bp_awready1", 32'(s_axi.awready), 32'd1);
    @(posedge clk); #1;
    s_axi.awaddr = 4'hC; s_axi.wdata = 32'h2222_2222;
    aw_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s_axi.awready) aw_seen = 1'b1;
    end
    check("bp_aw_blocked", 32'(aw_seen), 32'd0);
    check("bp_b_held", 32'(s_axi.bvalid), 32'd1);
    check("bp_src_o", src_addr_o, 32'h1111_1111);
    check("bp_dst_kept", dst_addr_o, 32'hCAFE_0000);
    s_axi.bready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axi.awready) break;
    end
    check("bp_awready2", 32'(s_axi.awready), 32'd1);
    @(posedge clk); #1;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axi.bvalid) break;
    end
    check("bp_bvalid2", 32'(s_axi.bvalid), 32'd1);
    @(posedge clk); #1;
    check("bp_dst_o", dst_addr_o, 32'h2222_2222);

    // Reset with an R beat pending.
    axi_read(4'h8, 1'b0, rd, resp);
    check("pend_rdata", rd, 32'h1111_1111);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rvalid", 32'(s_axi.rvalid), 32'd0);
    check("arst_rdata", s_axi.rdata, 32'd0);
    check("arst_src_o", src_addr_o, 32'h1000_0000);
    check("arst_dst_o", dst_addr_o, 32'h1000_1000);
    @(negedge clk); rst_n = 1'b1; s_axi.rready = 1'b1;
    @(negedge clk);
    check("post_rst_rvalid", 32'(s_axi.rvalid), 32'd0);
    axi_read(4'h0, 1'b1, rd, resp);
    check("post_rst_ctrl", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/paillier_axi_lite_regs.md
Name: paillier_axi_lite_regs

Overview:
AXI4-Lite slave control/status register file for the Paillier accelerator. It is the responder to the AXI-Lite stimulus master and the host CPU. It holds the DMA source and destination addresses for the AXI-Full master, generates a one-cycle start pulse for the core, and captures the core's done event as a sticky, interrupt-capable status bit.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, AXI-Lite byte address width; decodes 4 word registers using addr[3:2].
C_SRC_ADDR_RESET, 32'h10000000, reset value of SRC_ADDR.
C_DST_ADDR_RESET, 32'h10001000, reset value of DST_ADDR.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset; one clock; asynchronous assert, active-low
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake
core_busy_i  in  1  core running
core_done_i  in  1  one-cycle done pulse from core
start_o  out  1  one-cycle start pulse to core
src_addr_o  out  32  SRC_ADDR register
dst_addr_o  out  32  DST_ADDR register
irq_o  out  1  interrupt, level-sensitive

Behaviour:
- Register map (addr[3:2]):
  - 0x0 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN (RW).
  - 0x4 STATUS: bit0 BUSY (RO, equals core_busy_i); bit1 DONE (sticky, write-1-to-clear).
  - 0x8 SRC_ADDR (RW).
  - 0xC DST_ADDR (RW).
  - Unused bits read 0. addr[1:0] ignored.
- Reset values: all READY/VALID outputs 0; BRESP = RRESP = 0; RDATA = 0; start_o = 0; IRQ_EN = 0; DONE = 0; SRC_ADDR = C_SRC_ADDR_RESET; DST_ADDR = C_DST_ADDR_RESET.
- Write channel:
  - If AWVALID & WVALID & ~BVALID & ~AWREADY at edge k, then AWREADY and WREADY are both 1 for exactly cycle k+1.
  - The register update occurs at the edge ending cycle k+1.
  - BVALID rises in cycle k+2 and holds until BREADY. A new write is not accepted while BVALID = 1.
  - AW or W arriving alone waits; no skid buffer.
- WSTRB: applies per byte to SRC_ADDR and DST_ADDR. CTRL and STATUS act only if WSTRB[0] = 1.
- START:
  - A write of CTRL with bit0 = 1 while core_busy_i = 0 gives start_o = 1 in the cycle after the write handshake edge, for exactly one cycle; BRESP = OKAY (2'b00).
  - The same write while core_busy_i = 1 gives no pulse and BRESP = SLVERR (2'b10). IRQ_EN is still updated.
- Address writes while busy are accepted; the core samples addresses at start.
- DONE:
  - Set by core_done_i; cleared by a STATUS write with bit1 = 1.
  - If set and clear occur in the same edge, set wins.
- irq_o = DONE & IRQ_EN (registered outputs, combinational AND).
- Read channel:
  - If ARVALID & ~ARREADY & ~RVALID at edge k, ARREADY = 1 in cycle k+1.
  - At the edge ending cycle k+1, RDATA is latched and RVALID = 1, held stable until RREADY. RRESP = OKAY.
  - Reading has no side effects.
- Reads and writes are independent and may overlap. A read of STATUS in the same edge as a DONE clear returns the pre-clear value.
- Reset asserted mid-transaction: all handshakes abort immediately and all registers return to reset values. No pending B or R beat survives.

Test Plan:
- Reset release, read all four addresses -> CTRL = 0, STATUS = 0, SRC = 0x10000000, DST = 0x10001000; RRESP = 0 each.
- Write SRC = 0xDEADBEEF with WSTRB = 4'b0101, then read back -> 0x10AD00EF; src_addr_o matches; BRESP = 0.
- Write CTRL = 0x3 with core_busy_i = 0 -> start_o high for exactly 1 cycle, one cycle after the handshake; CTRL reads 0x2.
- Hold core_busy_i = 1, write CTRL = 0x1 -> no start_o pulse; BRESP = 2'b10; STATUS reads 0x1.
- Pulse core_done_i with IRQ_EN = 1 -> STATUS bit1 = 1, irq_o = 1. Write STATUS = 0x2 in the same edge as a second core_done_i pulse -> DONE stays 1. A later write of 0x2 -> irq_o = 0.
- Hold BREADY = 0 and issue a second AW/W -> AWREADY stays 0 until B is accepted. Assert reset with RVALID pending -> RVALID = 0 immediately.
